// File: rtl/id_stage_pipe.sv
// Instruction decode stage: field decode, register bank with write-back bypass,
// immediate extension and a registered ID/EX stage with load-use stall and flush.
module id_stage_pipe #(
  parameter int DATA_W  = 32,
  parameter int NREG    = 16,
  parameter int R0_ZERO = 1,
  parameter int BYPASS  = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  input  logic [31:0]       in_pc,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [3:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_type,
  output logic [4:0]        out_op,
  output logic [3:0]        out_wc,
  output logic              out_we,
  output logic [DATA_W-1:0] out_pra,
  output logic [DATA_W-1:0] out_prb,
  output logic [DATA_W-1:0] out_imm,
  output logic [31:0]       out_pc
);

  localparam logic [4:0] NREG_L    = 5'(NREG);
  localparam logic [2:0] T_ALU_RR  = 3'b001;
  localparam logic [2:0] T_ALU_IMM = 3'b010;
  localparam logic [2:0] T_LOG_IMM = 3'b011;
  localparam logic [2:0] T_LOAD    = 3'b100;
  localparam logic [2:0] T_STORE   = 3'b101;
  localparam logic [2:0] T_BRANCH  = 3'b110;

  logic [2:0]        type_f;
  logic [4:0]        op_f;
  logic [3:0]        wc_f;
  logic [3:0]        ra_f;
  logic [3:0]        rb_f;
  logic [15:0]       imm_f;
  logic              reads_ra;
  logic              reads_rb;
  logic              writes;
  logic              wb_act;
  logic              hazard;
  logic [DATA_W-1:0] pra;
  logic [DATA_W-1:0] prb;
  logic [DATA_W-1:0] imm_s;
  logic [DATA_W-1:0] imm_z;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] regs [16];

  function automatic logic in_bank(input logic [3:0] a);
    return ({1'b0, a} < NREG_L);
  endfunction

  function automatic logic zero_reg(input logic [3:0] a);
    return (R0_ZERO != 0) && (a == 4'd0);
  endfunction

  assign type_f = instruction[31:29];
  assign op_f   = instruction[28:24];
  assign wc_f   = instruction[23:20];
  assign ra_f   = instruction[19:16];
  assign rb_f   = instruction[15:12];
  assign imm_f  = instruction[15:0];

  always_comb begin
    reads_ra = 1'b0;
    reads_rb = 1'b0;
    writes   = 1'b0;
    case (type_f)
      T_ALU_RR:  begin reads_ra = 1'b1; reads_rb = 1'b1; writes = 1'b1; end
      T_ALU_IMM,
      T_LOG_IMM,
      T_LOAD:    begin reads_ra = 1'b1; writes = 1'b1; end
      T_STORE:   begin reads_ra = 1'b1; reads_rb = 1'b1; end
      T_BRANCH:  reads_ra = 1'b1;
      default:   ;
    endcase
  end

  // Replication of zero width is illegal, so the 16-bit case is split out.
  if (DATA_W > 16) begin : g_ext
    assign imm_s = {{(DATA_W-16){imm_f[15]}}, imm_f};
    assign imm_z = {{(DATA_W-16){1'b0}}, imm_f};
  end else begin : g_noext
    assign imm_s = imm_f;
    assign imm_z = imm_f;
  end

  assign imm_ext = (type_f == T_LOG_IMM) ? imm_z : imm_s;

  assign wb_act = !RST && wb_en && in_bank(wb_addr) && !zero_reg(wb_addr);

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (wb_act) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    pra = '0;
    if (in_bank(ra_f) && !zero_reg(ra_f)) begin
      if ((BYPASS != 0) && wb_act && (wb_addr == ra_f)) pra = wb_data;
      else                                             pra = regs[ra_f];
    end
  end

  always_comb begin
    prb = '0;
    if (in_bank(rb_f) && !zero_reg(rb_f)) begin
      if ((BYPASS != 0) && wb_act && (wb_addr == rb_f)) prb = wb_data;
      else                                             prb = regs[rb_f];
    end
  end

  // A load in ID/EX whose destination feeds the instruction in ID forces one bubble.
  assign hazard = in_valid && out_valid && (out_type == T_LOAD) &&
                  ((reads_ra && (ra_f == out_wc) && !zero_reg(ra_f)) ||
                   (reads_rb && (rb_f == out_wc) && !zero_reg(rb_f)));

  assign in_ready = !RST && !flush && !hazard && (!out_valid || out_ready);

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid <= 1'b0;
      out_type  <= '0;
      out_op    <= '0;
      out_wc    <= '0;
      out_we    <= 1'b0;
      out_pra   <= '0;
      out_prb   <= '0;
      out_imm   <= '0;
      out_pc    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_type  <= type_f;
      out_op    <= op_f;
      out_wc    <= wc_f;
      out_we    <= writes;
      out_pra   <= pra;
      out_prb   <= prb;
      out_imm   <= imm_ext;
      out_pc    <= in_pc;
    end else if (hazard && out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench: a 32-bit bypassing instance and a 16-bit, 12-register, non-bypassing
// instance share all stimulus and are checked against one behavioural model.
module tb_id_stage_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, flush, wb_en, out_ready;
  logic [31:0] instruction, in_pc, wb_data;
  logic [3:0]  wb_addr;

  logic        in_ready, out_valid, out_we;
  logic [2:0]  out_type;
  logic [4:0]  out_op;
  logic [3:0]  out_wc;
  logic [31:0] out_pra, out_prb, out_imm, out_pc;

  logic        a_in_ready, a_out_valid, a_out_we;
  logic [2:0]  a_out_type;
  logic [4:0]  a_out_op;
  logic [3:0]  a_out_wc;
  logic [15:0] a_out_pra, a_out_prb, a_out_imm;
  logic [31:0] a_out_pc;

  id_stage_pipe #(.DATA_W(32), .NREG(16), .R0_ZERO(1), .BYPASS(1)) dut (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .in_pc(in_pc), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
    .out_op(out_op), .out_wc(out_wc), .out_we(out_we), .out_pra(out_pra),
    .out_prb(out_prb), .out_imm(out_imm), .out_pc(out_pc));

  id_stage_pipe #(.DATA_W(16), .NREG(12), .R0_ZERO(1), .BYPASS(0)) alt (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .instruction(instruction), .in_pc(in_pc), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data[15:0]),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_type(a_out_type),
    .out_op(a_out_op), .out_wc(a_out_wc), .out_we(a_out_we), .out_pra(a_out_pra),
    .out_prb(a_out_prb), .out_imm(a_out_imm), .out_pc(a_out_pc));

  typedef struct {
    logic [2:0]  t;
    logic [4:0]  op;
    logic [3:0]  wc;
    logic        we;
    logic [31:0] pc;
    logic [31:0] pra, prb, imm;
    logic [15:0] apra, aprb, aimm;
    bit          ura, urb;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mr [16];
  logic [15:0] ar [16];
  bit          m_valid;
  logic [2:0]  m_type;
  logic [3:0]  m_wc;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit uses_ra(input logic [2:0] t);
    return (t >= 3'd1) && (t <= 3'd6);
  endfunction

  function automatic bit uses_rb(input logic [2:0] t);
    return (t == 3'd1) || (t == 3'd5);
  endfunction

  function automatic bit does_write(input logic [2:0] t);
    return (t >= 3'd1) && (t <= 3'd4);
  endfunction

  // Full-width bank: 16 registers, r0 hardwired, write-back forwarded.
  function automatic logic [31:0] m_read(input logic [3:0] a);
    if (a == 4'd0) return 32'd0;
    if (wb_en && wb_addr == a) return wb_data;
    return mr[a];
  endfunction

  // Narrow bank: 12 registers, r0 hardwired, no forwarding.
  function automatic logic [15:0] a_read(input logic [3:0] a);
    if (a == 4'd0 || a >= 4'd12) return 16'd0;
    return ar[a];
  endfunction

  function automatic logic [31:0] mk(input logic [2:0] t, input logic [4:0] op,
                                     input logic [3:0] wc, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [11:0] lo);
    return {t, op, wc, ra, rb, lo};
  endfunction

  task automatic step();
    bit hz, er, acc;
    logic [2:0] t;
    logic [3:0] ra, rb;
    logic [15:0] im;
    exp_t e;
    @(negedge clk);
    t  = instruction[31:29];
    ra = instruction[19:16];
    rb = instruction[15:12];
    im = instruction[15:0];
    hz = in_valid && m_valid && (m_type == 3'd4) && (m_wc != 4'd0) &&
         ((uses_ra(t) && ra == m_wc) || (uses_rb(t) && rb == m_wc));
    er = !rst && !flush && !hz && (!m_valid || out_ready);
    check("in_ready", {63'd0, in_ready}, {63'd0, er});
    check("alt_in_ready", {63'd0, a_in_ready}, {63'd0, er});
    check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    check("alt_out_valid", {63'd0, a_out_valid}, {63'd0, m_valid});
    acc = in_valid && er;
    if (acc) begin
      e.t    = t;
      e.op   = instruction[28:24];
      e.wc   = instruction[23:20];
      e.we   = does_write(t);
      e.pc   = in_pc;
      e.pra  = m_read(ra);
      e.prb  = m_read(rb);
      e.imm  = (t == 3'd3) ? {16'd0, im} : {{16{im[15]}}, im};
      e.apra = a_read(ra);
      e.aprb = a_read(rb);
      e.aimm = im;
      e.ura  = uses_ra(t);
      e.urb  = uses_rb(t);
      q.push_back(e);
    end
    if (rst) q.delete();
    else if (flush && m_valid && q.size() > 0) void'(q.pop_front());
    if (rst || flush) m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1;
      m_type  = t;
      m_wc    = instruction[23:20];
    end else if (m_valid && out_ready) m_valid = 1'b0;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin mr[i] = '0; ar[i] = '0; end
    end else if (wb_en && wb_addr != 4'd0) begin
      mr[wb_addr] = wb_data;
      if (wb_addr < 4'd12) ar[wb_addr] = wb_data[15:0];
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: whenever the stage presents an op, it must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && !flush && out_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=valid required=empty at %0t", $time);
        end else begin
          e = q[0];
          if (out_ready) void'(q.pop_front());
          check("id_fields", {19'd0, out_type, out_op, out_wc, out_we, out_pc},
                {19'd0, e.t, e.op, e.wc, e.we, e.pc});
          check("imm", {32'd0, out_imm}, {32'd0, e.imm});
          if (e.ura) check("pra", {32'd0, out_pra}, {32'd0, e.pra});
          if (e.urb) check("prb", {32'd0, out_prb}, {32'd0, e.prb});
          check("alt_id_fields", {19'd0, a_out_type, a_out_op, a_out_wc, a_out_we, a_out_pc},
                {19'd0, e.t, e.op, e.wc, e.we, e.pc});
          check("alt_imm", {48'd0, a_out_imm}, {48'd0, e.aimm});
          if (e.ura) check("alt_pra", {48'd0, a_out_pra}, {48'd0, e.apra});
          if (e.urb) check("alt_prb", {48'd0, a_out_prb}, {48'd0, e.aprb});
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
    instruction = '0; in_pc = '0; wb_addr = '0; wb_data = '0;
    m_valid = 1'b0; m_type = '0; m_wc = '0;
    for (int i = 0; i < 16; i++) begin mr[i] = '0; ar[i] = '0; end
    step(); step();
    rst = 1'b0;

    // Every register reads zero after reset.
    in_valid = 1'b1;
    for (int i = 1; i < 16; i++) begin
      instruction = mk(3'd1, 5'(i), 4'(i), 4'(i), 4'(i), 12'd0);
      in_pc = 32'(i * 4);
      step();
    end
    in_valid = 1'b0; step();

    // Same-cycle write-back and read of r3.
    wb_en = 1'b1; wb_addr = 4'd3; wb_data = 32'hDEADBEEF;
    in_valid = 1'b1; instruction = mk(3'd1, 5'd2, 4'd9, 4'd3, 4'd0, 12'd0); in_pc = 32'h100;
    step();
    wb_en = 1'b0; in_valid = 1'b0; step();

    // Signed versus zero-extended immediate.
    in_valid = 1'b1;
    instruction = mk(3'd2, 5'd1, 4'd1, 4'd3, 4'd8, 12'h001); in_pc = 32'h104; step();
    instruction = mk(3'd3, 5'd1, 4'd1, 4'd3, 4'd8, 12'h001); in_pc = 32'h108; step();
    in_valid = 1'b0; step();

    // Load-use pair on r5, then a load to r0 which must not stall.
    in_valid = 1'b1;
    instruction = mk(3'd4, 5'd0, 4'd5, 4'd1, 4'd0, 12'h010); in_pc = 32'h200; step();
    instruction = mk(3'd1, 5'd0, 4'd6, 4'd5, 4'd2, 12'h000); in_pc = 32'h204; step(); step(); step();
    in_valid = 1'b0; step();
    in_valid = 1'b1;
    instruction = mk(3'd4, 5'd0, 4'd0, 4'd1, 4'd0, 12'h010); in_pc = 32'h300; step();
    instruction = mk(3'd1, 5'd0, 4'd6, 4'd0, 4'd0, 12'h000); in_pc = 32'h304; step();
    in_valid = 1'b0; step();

    // Backpressure for three cycles, then consume and accept on the same edge.
    in_valid = 1'b1; out_ready = 1'b1;
    instruction = mk(3'd2, 5'd7, 4'd4, 4'd3, 4'd1, 12'h234); in_pc = 32'h400; step();
    out_ready = 1'b0;
    instruction = mk(3'd5, 5'd3, 4'd0, 4'd3, 4'd9, 12'h567); in_pc = 32'h404;
    step(); step(); step();
    out_ready = 1'b1; step();
    in_valid = 1'b0; step();

    // Flush with an op held and one presented; write-back in the flush cycle persists.
    in_valid = 1'b1;
    instruction = mk(3'd1, 5'd1, 4'd2, 4'd3, 4'd3, 12'h000); in_pc = 32'h500; step();
    out_ready = 1'b0; flush = 1'b1;
    wb_en = 1'b1; wb_addr = 4'd7; wb_data = 32'h1234_5678;
    instruction = mk(3'd1, 5'd2, 4'd2, 4'd1, 4'd1, 12'h000); in_pc = 32'h504; step();
    flush = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
    instruction = mk(3'd1, 5'd3, 4'd2, 4'd7, 4'd7, 12'h000); in_pc = 32'h508; step();
    in_valid = 1'b0; step();

    // Randomized traffic with small register indices so hazards and bypasses are frequent.
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 7);
      wb_en     = $urandom_range(0, 1) == 1;
      wb_addr   = 4'($urandom_range(0, 15));
      wb_data   = $urandom;
      instruction = mk(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                       4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                       4'($urandom_range(0, 13)), 12'($urandom_range(0, 4095)));
      in_pc = $urandom;
      step();
    end

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; wb_en = 1'b0;
    step(); step(); step();
    check("queue_drained", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
